// File: rtl/hpdl1414_char_writer.sv
// rtl/hpdl1414_char_writer.sv - byte strobes to HPDL-1414 character writes with scrolling shadow
// Optional HPDL_CASE_FOLD_EN folds 0x60-0x7E onto upper case instead of discarding them.

module hpdl1414_byte_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
endmodule

module hpdl1414_char_writer #(
   parameter int FIFO_DEPTH   = 4,
   parameter int SETUP_CYCLES = 2,
   parameter int WR_CYCLES    = 3,
   parameter int HOLD_CYCLES  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       ovf_clr,
   output logic       busy,
   output logic       ovf,
   output logic [1:0] disp_addr,
   output logic [6:0] disp_data,
   output logic       disp_wr_n
);
   localparam int MAX_AB  = (SETUP_CYCLES > WR_CYCLES) ? SETUP_CYCLES : WR_CYCLES;
   localparam int MAX_CYC = (MAX_AB > HOLD_CYCLES) ? MAX_AB : HOLD_CYCLES;
   localparam int CW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_SETUP, S_STROBE, S_HOLD} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_digit;
   logic [7:0]    r_cur;
   logic [6:0]    r_shadow [4];
   logic          r_ovf;
   logic          r_wr_n;
   logic [1:0]    r_addr;
   logic [6:0]    r_data;

   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic [7:0]    w_fifo_data;
   logic          w_print;
   logic          w_cr;
   logic [6:0]    w_char;
   logic [6:0]    w_next [4];
   logic [1:0]    w_dig_dn;

   // A full FIFO still accepts a byte when the FSM pops in the same cycle.
   assign w_pop    = (r_state == S_IDLE) && !w_empty;
   assign w_push   = in_valid && (!w_full || w_pop);
   assign w_drop   = in_valid && w_full && !w_pop;
   assign w_dig_dn = r_digit - 2'd1;

   hpdl1414_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (in_data),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_comb begin
      w_print = 1'b0;
      w_cr    = 1'b0;
      w_char  = r_cur[6:0];
      if (r_cur >= 8'h20 && r_cur <= 8'h5F) begin
         w_print = 1'b1;
      end else if (r_cur == 8'h0D) begin
         w_cr = 1'b1;
`ifdef HPDL_CASE_FOLD_EN
      end else if (r_cur >= 8'h60 && r_cur <= 8'h7E) begin
         w_print = 1'b1;
         w_char  = r_cur[6:0] - 7'h20;
`endif
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) w_next[i] = r_shadow[i];
      if (w_cr) begin
         for (int i = 0; i < 4; i++) w_next[i] = 7'h20;
      end else if (w_print) begin
         w_next[3] = r_shadow[2];
         w_next[2] = r_shadow[1];
         w_next[1] = r_shadow[0];
         w_next[0] = w_char;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   // Reset lands in SETUP on digit 3 so the display is blanked after every reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_SETUP;
         r_cnt   <= '0;
         r_digit <= 2'd3;
         r_cur   <= 8'h00;
         for (int i = 0; i < 4; i++) r_shadow[i] <= 7'h20;
         r_wr_n  <= 1'b1;
         r_addr  <= 2'd3;
         r_data  <= 7'h20;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_cur   <= w_fifo_data;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (w_print || w_cr) begin
                  for (int i = 0; i < 4; i++) r_shadow[i] <= w_next[i];
                  r_digit <= 2'd3;
                  r_addr  <= 2'd3;
                  r_data  <= w_next[3];
                  r_cnt   <= '0;
                  r_state <= S_SETUP;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_SETUP: begin
               if (r_cnt == CW'(SETUP_CYCLES - 1)) begin
                  r_cnt   <= '0;
                  r_wr_n  <= 1'b0;
                  r_state <= S_STROBE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_STROBE: begin
               if (r_cnt == CW'(WR_CYCLES - 1)) begin
                  r_cnt   <= '0;
                  r_wr_n  <= 1'b1;
                  r_state <= S_HOLD;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_HOLD: begin
               if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
                  r_cnt <= '0;
                  if (r_digit == 2'd0) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_digit <= w_dig_dn;
                     r_addr  <= w_dig_dn;
                     r_data  <= r_shadow[w_dig_dn];
                     r_state <= S_SETUP;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = !w_empty || (r_state != S_IDLE);
   assign ovf       = r_ovf;
   assign disp_addr = r_addr;
   assign disp_data = r_data;
   assign disp_wr_n = r_wr_n;
endmodule

// File: tb/tb_hpdl1414_char_writer.sv
// tb/tb_hpdl1414_char_writer.sv - table-driven bench for hpdl1414_char_writer
module tb_hpdl1414_char_writer;
   localparam int SETUP   = 2;
   localparam int WRC     = 3;
   localparam int HOLD    = 1;
   localparam int REFRESH = 4 * (SETUP + WRC + HOLD);
   localparam int NV      = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       ovf_clr = 1'b0;
   logic       busy;
   logic       ovf;
   logic [1:0] disp_addr;
   logic [6:0] disp_data;
   logic       disp_wr_n;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   logic mon_en = 1'b0;

   logic [1:0] wq_addr [$];
   logic [6:0] wq_data [$];
   int         wq_cyc  [$];

   typedef struct {
      logic [7:0]      b;
      int              n;
      logic [3:0][6:0] d;
   } vec_t;
   vec_t vecs [NV];

   hpdl1414_char_writer #(
      .FIFO_DEPTH   (4),
      .SETUP_CYCLES (SETUP),
      .WR_CYCLES    (WRC),
      .HOLD_CYCLES  (HOLD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .ovf_clr   (ovf_clr),
      .busy      (busy),
      .ovf       (ovf),
      .disp_addr (disp_addr),
      .disp_data (disp_data),
      .disp_wr_n (disp_wr_n)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Bus monitor: captures each write and checks pulse width and addr/data stability.
   logic       m_pw = 1'b1;
   logic [1:0] m_pa = 2'd3;
   logic [6:0] m_pd = 7'h20;
   logic       m_chg;
   int         m_stable = 100;
   int         m_low = 0;
   int         m_age = 100;

   always @(negedge clk) begin
      m_chg = (disp_addr != m_pa) || (disp_data != m_pd);
      if (m_pw && !disp_wr_n) begin
         if (mon_en) begin
            wq_addr.push_back(disp_addr);
            wq_data.push_back(disp_data);
            wq_cyc.push_back(cyc);
            check("setup_len", (m_stable >= SETUP) ? SETUP : m_stable, SETUP);
         end
         m_low = 1;
      end else if (!disp_wr_n) begin
         m_low++;
      end
      if (!m_pw && disp_wr_n) begin
         if (mon_en) check("wr_low_len", m_low, WRC);
         m_age = 1;
      end else if (m_age < 1000) begin
         m_age++;
      end
      if (m_chg) begin
         if (mon_en) check("addr_data_stable", (disp_wr_n && m_age > HOLD) ? 1 : 0, 1);
         m_stable = 1;
      end else if (disp_wr_n) begin
         m_stable++;
      end
      m_pw = disp_wr_n;
      m_pa = disp_addr;
      m_pd = disp_data;
   end

   task automatic set_vec(input int i, input logic [7:0] b, input int n, input logic [27:0] d);
      vecs[i].b = b;
      vecs[i].n = n;
      vecs[i].d = d;
   endtask

   task automatic clear_q();
      wq_addr.delete();
      wq_data.delete();
      wq_cyc.delete();
   endtask

   task automatic wait_idle(input int bound, output int t);
      int k;
      k = 0;
      @(negedge clk);
      while (busy && k < bound) begin
         @(negedge clk);
         k++;
      end
      if (busy) check("idle_timeout", 0, 1);
      t = cyc;
   endtask

   task automatic check_four(input string tag, input logic [3:0][6:0] d, input int base);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_addr%0d", tag, i), int'(wq_addr[base+i]), 3 - i);
         check($sformatf("%s_data%0d", tag, i), int'(wq_data[base+i]), int'(d[3-i]));
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output int n0);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = b;
      n0 = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_burst();
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_data  = 8'h41 + 8'(k);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int t;
      int r0;
      int n0;
      int k;

      set_vec(0,  8'h41, 4, {7'h20, 7'h20, 7'h20, 7'h41});
      set_vec(1,  8'h07, 0, '0);
      set_vec(2,  8'h7F, 0, '0);
      set_vec(3,  8'hC1, 0, '0);
      set_vec(4,  8'h5F, 4, {7'h20, 7'h20, 7'h41, 7'h5F});
      set_vec(5,  8'h20, 4, {7'h20, 7'h41, 7'h5F, 7'h20});
`ifdef HPDL_CASE_FOLD_EN
      set_vec(6,  8'h61, 4, {7'h41, 7'h5F, 7'h20, 7'h41});
      set_vec(7,  8'h2A, 4, {7'h5F, 7'h20, 7'h41, 7'h2A});
`else
      set_vec(6,  8'h61, 0, '0);
      set_vec(7,  8'h2A, 4, {7'h41, 7'h5F, 7'h20, 7'h2A});
`endif
      set_vec(8,  8'h0D, 4, {7'h20, 7'h20, 7'h20, 7'h20});
      set_vec(9,  8'h48, 4, {7'h20, 7'h20, 7'h20, 7'h48});
      set_vec(10, 8'h49, 4, {7'h20, 7'h20, 7'h48, 7'h49});
      set_vec(11, 8'h0D, 4, {7'h20, 7'h20, 7'h20, 7'h20});
`ifdef HPDL_CASE_FOLD_EN
      set_vec(12, 8'h7E, 4, {7'h20, 7'h20, 7'h20, 7'h5E});
      set_vec(13, 8'h60, 4, {7'h20, 7'h20, 7'h5E, 7'h40});
      set_vec(14, 8'h5A, 4, {7'h20, 7'h5E, 7'h40, 7'h5A});
`else
      set_vec(12, 8'h7E, 0, '0);
      set_vec(13, 8'h60, 0, '0);
      set_vec(14, 8'h5A, 4, {7'h20, 7'h20, 7'h20, 7'h5A});
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_wr_n", int'(disp_wr_n), 1);
      check("rst_addr", int'(disp_addr), 3);
      check("rst_data", int'(disp_data), 32'h20);
      check("rst_ovf", int'(ovf), 0);

      @(posedge clk); #1;
      rst_n  = 1'b1;
      r0     = cyc;
      mon_en = 1'b1;
      wait_idle(200, t);
      check("blank_time", t - r0, REFRESH);
      check("blank_nwr", wq_data.size(), 4);
      if (wq_data.size() == 4) check_four("blank", {7'h20, 7'h20, 7'h20, 7'h20}, 0);

      for (int i = 0; i < NV; i++) begin
         clear_q();
         send_byte(vecs[i].b, n0);
         wait_idle(200, t);
         check($sformatf("v%0d_nwr", i), wq_data.size(), vecs[i].n);
         if (vecs[i].n == 4 && wq_data.size() == 4) begin
            check($sformatf("v%0d_latency", i), wq_cyc[0] - n0, SETUP + 3);
            check_four($sformatf("v%0d", i), vecs[i].d, 0);
         end
      end

      clear_q();
      check("burst_ovf_pre", int'(ovf), 0);
      send_burst();
      wait_idle(1000, t);
      check("burst_nwr", wq_data.size(), 20);
      check("burst_ovf", int'(ovf), 1);
      if (wq_data.size() == 20) check_four("burst_final", {7'h42, 7'h43, 7'h44, 7'h45}, 16);
      @(posedge clk); #1;
      ovf_clr = 1'b1;
      @(posedge clk); #1;
      ovf_clr = 1'b0;
      @(negedge clk);
      check("ovf_clr", int'(ovf), 0);

      clear_q();
      send_byte(8'h07, n0);
      @(negedge clk);
      check("bel_busy_n1", int'(busy), 1);
      @(negedge clk);
      check("bel_busy_n2", int'(busy), 1);
      @(negedge clk);
      check("bel_busy_n3", int'(busy), 0);
      repeat (10) @(negedge clk);
      check("bel_nwr", wq_data.size(), 0);

      send_burst();
      k = 0;
      while (disp_wr_n && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("mid_wr_low", int'(disp_wr_n), 0);
      repeat (2) @(negedge clk);
      check("mid_ovf_pre", int'(ovf), 1);
      check("mid_wr_still_low", int'(disp_wr_n), 0);
      mon_en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_wr_n", int'(disp_wr_n), 1);
      check("mid_rst_addr", int'(disp_addr), 3);
      check("mid_rst_data", int'(disp_data), 32'h20);
      check("mid_rst_ovf", int'(ovf), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      r0    = cyc;
      clear_q();
      mon_en = 1'b1;
      wait_idle(400, t);
      check("mid_blank_time", t - r0, REFRESH);
      check("mid_blank_nwr", wq_data.size(), 4);
      if (wq_data.size() == 4) check_four("mid_blank", {7'h20, 7'h20, 7'h20, 7'h20}, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
